pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the PC register and sequences instruction fetch for the MIPS core.
//  Handshakes with instruction memory and raises inst_valid for decode.
//  Resolves competing redirects (exception, jump, branch) and drives the next-PC mux select.
//  Sits between imem, the next-PC mux and decode/control.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC loaded on reset
//  EXC_VECTOR  32'h0000_4180  PC loaded on exception or misaligned target
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   synchronous active-low reset
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  fetch address (== pc)
//  imem_ack       in   1   imem data valid this cycle
//  inst_valid     out  1   fetched instruction is presented to decode
//  stall          in   1   hazard hold; freezes EXEC
//  branch_req     in   1   current instruction is a branch
//  branch_taken   in   1   branch condition true (qualified by branch_req)
//  branch_target  in   32  branch destination
//  jump_req       in   1   current instruction is j/jal/jr
//  jump_target    in   32  jump destination
//  exc_req        in   1   exception request (any state)
//  pc             out  32  current PC
//  pc_add4        out  32  pc + 4 (mod 2^32)
//  next_sel       out  2   next-PC mux select: `NextIns/`Jump/`Branch/`Zero (define.v)
//  exc_taken      out  1   one-cycle pulse when the vector is loaded
//  epc            out  32  PC of the instruction that took the exception
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, exc_pend=0, epc=0; imem_req=0,
//    inst_valid=0, exc_taken=0, next_sel=`NextIns. Mid-operation reset aborts any fetch.
//  States: FETCH, WAIT, EXEC.
//   FETCH: imem_req=1, imem_addr=pc. ack -> EXEC, else -> WAIT.
//   WAIT: imem_req=1, addr held stable. ack -> EXEC.
//   EXEC: inst_valid=1. stall=1 holds EXEC, pc unchanged, inst_valid stays 1.
//     stall=0: pc <= selected next PC, -> FETCH.
//  Minimum throughput: 2 cycles per instruction (ack in FETCH).
//  Next-PC priority in EXEC: exc (exc_req|exc_pend) > jump_req > branch_req&branch_taken > pc+4.
//   next_sel: exc->`Zero (EXC_VECTOR), jump->`Jump, taken branch->`Branch, else `NextIns.
//   next_sel is combinational; it is valid only in EXEC and is `NextIns in other states.
//   Branch and jump inputs are ignored outside EXEC.
//  Misaligned target (selected target[1:0]!=0): treated as an exception.
//   next_sel=`Zero, pc<=EXC_VECTOR, epc<=pc.
//  Exception handling:
//   exc_req in FETCH/WAIT sets exc_pend. The fetch completes (ack).
//   EXEC is then entered with inst_valid=0 (the instruction is squashed); no stall wait.
//   The vector is loaded next edge with epc<=fetch pc.
//   exc_req in EXEC overrides stall: vector loaded that edge, epc<=pc.
//   Loading the vector pulses exc_taken=1 and clears exc_pend.
//  Simultaneous jump_req and taken branch: jump wins.
//  exc_req together with a misaligned target: a single exception.
//  pc_add4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
// TESTING
//  Reset, then ack in every FETCH -> imem_addr 0x3000, 0x3004, 0x3008...
//    One inst_valid per 2 cycles.
//  Ack delayed 3 cycles -> imem_req held, imem_addr stable, inst_valid only after ack.
//  EXEC at pc=0x3010 with jump_req=1 (target 0x3100) and branch taken (target 0x3020)
//    -> next_sel=`Jump, pc=0x3100.
//  stall=1 for 4 cycles at pc=0x3008 -> pc/inst_valid frozen; pc=0x300C after release.
//  exc_req pulse during WAIT at pc=0x3004 -> after ack, inst_valid=0;
//    next edge pc=0x4180, epc=0x3004, exc_taken pulse.
//  Branch target 0x3022 taken -> pc=0x4180, exc_taken=1.
//  rst_n low mid-WAIT -> pc=0x3000, imem_req=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  // Sequencer side issues requests; memory side acknowledges.
  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// PC register owner and fetch sequencer: FETCH/WAIT/EXEC loop with
// exception/jump/branch redirect arbitration and next-PC mux select.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.master imem,
  output logic          inst_valid,
  input  logic          stall,
  input  logic          branch_req,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump_req,
  input  logic [31:0]   jump_target,
  input  logic          exc_req,
  output logic [31:0]   pc,
  output logic [31:0]   pc_add4,
  output logic [1:0]    next_sel,
  output logic          exc_taken,
  output logic [31:0]   epc
);

  // Next-PC mux select encodings.
  localparam logic [1:0] NextIns = 2'b00;
  localparam logic [1:0] Jump    = 2'b01;
  localparam logic [1:0] Branch  = 2'b10;
  localparam logic [1:0] Zero    = 2'b11;

  localparam logic [1:0] StFetch = 2'b00;
  localparam logic [1:0] StWait  = 2'b01;
  localparam logic [1:0] StExec  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_pend_q, exc_pend_d;
  logic        exc_taken_q, exc_taken_d;

  logic [31:0] redirect_target;
  logic        take_exc;

  assign pc_add4 = pc_q + 32'd4;

  // Redirect arbitration in EXEC: exception > jump > taken branch > pc+4.
  // A misaligned selected target is folded into the exception path.
  always_comb begin
    redirect_target = pc_add4;
    next_sel        = NextIns;
    take_exc        = 1'b0;
    if (state_q == StExec) begin
      if (jump_req) begin
        redirect_target = jump_target;
        next_sel        = Jump;
      end else if (branch_req && branch_taken) begin
        redirect_target = branch_target;
        next_sel        = Branch;
      end
      if (exc_req || exc_pend_q || (redirect_target[1:0] != 2'b00)) begin
        take_exc = 1'b1;
        next_sel = Zero;
      end
    end
  end

  // Fetch sequencing and PC/EPC update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    exc_pend_d  = exc_pend_q;
    exc_taken_d = 1'b0;
    case (state_q)
      StFetch, StWait: begin
        // Exception during fetch: let the fetch finish, squash it in EXEC.
        if (exc_req) exc_pend_d = 1'b1;
        state_d = imem.imem_ack ? StExec : StWait;
      end
      StExec: begin
        if (take_exc) begin
          // Exceptions do not wait for stall release.
          pc_d        = EXC_VECTOR;
          epc_d       = pc_q;
          exc_pend_d  = 1'b0;
          exc_taken_d = 1'b1;
          state_d     = StFetch;
        end else if (!stall) begin
          pc_d    = redirect_target;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      epc_q       <= 32'h0;
      exc_pend_q  <= 1'b0;
      exc_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      exc_pend_q  <= exc_pend_d;
      exc_taken_q <= exc_taken_d;
    end
  end

  // Outputs are gated by rst_n so a held reset presents an idle interface.
  assign imem.imem_req  = rst_n && ((state_q == StFetch) || (state_q == StWait));
  assign imem.imem_addr = pc_q;
  assign inst_valid     = rst_n && (state_q == StExec) && !exc_pend_q;
  assign pc             = pc_q;
  assign epc            = epc_q;
  assign exc_taken      = exc_taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer.
module tb_pc_sequencer;

  localparam logic [1:0] NEXT_INS = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic        stall;
  logic        branch_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_add4;
  logic [1:0]  next_sel;
  logic        exc_taken;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  pc_sequencer_if imem_bus ();

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .inst_valid   (inst_valid),
    .stall        (stall),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_req     (jump_req),
    .jump_target  (jump_target),
    .exc_req      (exc_req),
    .pc           (pc),
    .pc_add4      (pc_add4),
    .next_sel     (next_sel),
    .exc_taken    (exc_taken),
    .epc          (epc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_req = 0; branch_taken = 0; branch_target = 0;
    jump_req = 0; jump_target = 0; exc_req = 0; imem_bus.imem_ack = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    settle();
  endtask

  // From FETCH, complete n instructions with immediate ack and no redirect.
  task automatic advance(input int n);
    repeat (n) begin
      imem_bus.imem_ack = 1;
      tick();
      imem_bus.imem_ack = 0;
      tick();
    end
  endtask

  // From FETCH, ack immediately and land in EXEC.
  task automatic to_exec();
    imem_bus.imem_ack = 1;
    tick();
    imem_bus.imem_ack = 0;
    settle();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b exp 0", imem_bus.imem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    total++; if (exc_taken !== 1'b0) begin bad++; $display("FAIL reset_exc_taken got %b exp 0", exc_taken); end
    total++; if (epc !== 32'h0) begin bad++; $display("FAIL reset_epc got %h exp 0", epc); end
    total++; if (next_sel !== NEXT_INS) begin bad++; $display("FAIL reset_sel got %b exp %b", next_sel, NEXT_INS); end
    rst_n = 1;
    settle();
    total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL post_reset_req got %b exp 1", imem_bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h3000 + 32'(4 * i);
      total++; if (imem_bus.imem_addr !== exp_pc) begin bad++; $display("FAIL seq_addr got %h exp %h", imem_bus.imem_addr, exp_pc); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL seq_fetch_valid got %b exp 0", inst_valid); end
      to_exec();
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL seq_exec_valid got %b exp 1", inst_valid); end
      total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL seq_exec_req got %b exp 0", imem_bus.imem_req); end
      total++; if (pc_add4 !== exp_pc + 32'd4) begin bad++; $display("FAIL seq_add4 got %h exp %h", pc_add4, exp_pc + 32'd4); end
      total++; if (next_sel !== NEXT_INS) begin bad++; $display("FAIL seq_sel got %b exp %b", next_sel, NEXT_INS); end
      tick();
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    repeat (3) begin
      tick();
      total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL wait_req got %b exp 1", imem_bus.imem_req); end
      total++; if (imem_bus.imem_addr !== 32'h3000) begin bad++; $display("FAIL wait_addr got %h exp %h", imem_bus.imem_addr, 32'h3000); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL wait_valid got %b exp 0", inst_valid); end
    end
    to_exec();
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL wait_ack_valid got %b exp 1", inst_valid); end
    tick();
    total++; if (pc !== 32'h3004) begin bad++; $display("FAIL wait_next_pc got %h exp %h", pc, 32'h3004); end
  endtask

  task automatic test_jump_branch();
    do_reset();
    advance(4);
    // Redirect inputs are ignored outside EXEC.
    jump_req = 1; jump_target = 32'h3100;
    settle();
    total++; if (next_sel !== NEXT_INS) begin bad++; $display("FAIL fetch_sel got %b exp %b", next_sel, NEXT_INS); end
    jump_req = 0;
    to_exec();
    total++; if (pc !== 32'h3010) begin bad++; $display("FAIL jb_pc got %h exp %h", pc, 32'h3010); end
    jump_req = 1; jump_target = 32'h3100;
    branch_req = 1; branch_taken = 1; branch_target = 32'h3020;
    settle();
    total++; if (next_sel !== SEL_JUMP) begin bad++; $display("FAIL jb_sel got %b exp %b", next_sel, SEL_JUMP); end
    tick();
    clear_inputs();
    total++; if (pc !== 32'h3100) begin bad++; $display("FAIL jb_target got %h exp %h", pc, 32'h3100); end
    to_exec();
    branch_req = 1; branch_taken = 0; branch_target = 32'h3200;
    settle();
    total++; if (next_sel !== NEXT_INS) begin bad++; $display("FAIL br_not_taken_sel got %b exp %b", next_sel, NEXT_INS); end
    branch_taken = 1;
    settle();
    total++; if (next_sel !== SEL_BR) begin bad++; $display("FAIL br_sel got %b exp %b", next_sel, SEL_BR); end
    tick();
    clear_inputs();
    total++; if (pc !== 32'h3200) begin bad++; $display("FAIL br_target got %h exp %h", pc, 32'h3200); end
  endtask

  task automatic test_stall();
    do_reset();
    advance(2);
    to_exec();
    stall = 1;
    repeat (4) begin
      tick();
      total++; if (pc !== 32'h3008) begin bad++; $display("FAIL stall_pc got %h exp %h", pc, 32'h3008); end
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got %b exp 1", inst_valid); end
    end
    stall = 0;
    tick();
    total++; if (pc !== 32'h300C) begin bad++; $display("FAIL stall_release got %h exp %h", pc, 32'h300C); end
  endtask

  task automatic test_exc_wait();
    do_reset();
    advance(1);
    tick();
    exc_req = 1;
    tick();
    exc_req = 0;
    total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL excw_req got %b exp 1", imem_bus.imem_req); end
    to_exec();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL excw_squash got %b exp 0", inst_valid); end
    total++; if (next_sel !== SEL_ZERO) begin bad++; $display("FAIL excw_sel got %b exp %b", next_sel, SEL_ZERO); end
    total++; if (exc_taken !== 1'b0) begin bad++; $display("FAIL excw_early got %b exp 0", exc_taken); end
    tick();
    total++; if (pc !== 32'h4180) begin bad++; $display("FAIL excw_pc got %h exp %h", pc, 32'h4180); end
    total++; if (epc !== 32'h3004) begin bad++; $display("FAIL excw_epc got %h exp %h", epc, 32'h3004); end
    total++; if (exc_taken !== 1'b1) begin bad++; $display("FAIL excw_pulse got %b exp 1", exc_taken); end
    tick();
    total++; if (exc_taken !== 1'b0) begin bad++; $display("FAIL excw_pulse_end got %b exp 0", exc_taken); end
  endtask

  task automatic test_misaligned();
    do_reset();
    to_exec();
    branch_req = 1; branch_taken = 1; branch_target = 32'h3022;
    settle();
    total++; if (next_sel !== SEL_ZERO) begin bad++; $display("FAIL mis_sel got %b exp %b", next_sel, SEL_ZERO); end
    tick();
    clear_inputs();
    total++; if (pc !== 32'h4180) begin bad++; $display("FAIL mis_pc got %h exp %h", pc, 32'h4180); end
    total++; if (exc_taken !== 1'b1) begin bad++; $display("FAIL mis_pulse got %b exp 1", exc_taken); end
    total++; if (epc !== 32'h3000) begin bad++; $display("FAIL mis_epc got %h exp %h", epc, 32'h3000); end
    // exc_req together with a misaligned jump: one exception only.
    to_exec();
    jump_req = 1; jump_target = 32'h5001; exc_req = 1;
    settle();
    total++; if (next_sel !== SEL_ZERO) begin bad++; $display("FAIL dual_sel got %b exp %b", next_sel, SEL_ZERO); end
    tick();
    clear_inputs();
    total++; if (epc !== 32'h4180) begin bad++; $display("FAIL dual_epc got %h exp %h", epc, 32'h4180); end
    total++; if (exc_taken !== 1'b1) begin bad++; $display("FAIL dual_pulse got %b exp 1", exc_taken); end
    tick();
    total++; if (exc_taken !== 1'b0) begin bad++; $display("FAIL dual_single got %b exp 0", exc_taken); end
  endtask

  task automatic test_exc_stall();
    do_reset();
    advance(1);
    to_exec();
    stall = 1; exc_req = 1;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h4180) begin bad++; $display("FAIL excs_pc got %h exp %h", pc, 32'h4180); end
    total++; if (epc !== 32'h3004) begin bad++; $display("FAIL excs_epc got %h exp %h", epc, 32'h3004); end
  endtask

  task automatic test_wrap();
    do_reset();
    to_exec();
    jump_req = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got %h exp %h", pc, 32'hFFFF_FFFC); end
    total++; if (pc_add4 !== 32'h0) begin bad++; $display("FAIL wrap_add4 got %h exp 0", pc_add4); end
    to_exec();
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_next got %h exp 0", pc); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    advance(1);
    tick();
    total++; if (imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL rmw_pre_req got %b exp 1", imem_bus.imem_req); end
    rst_n = 0;
    tick();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL rmw_pc got %h exp %h", pc, 32'h3000); end
    total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rmw_req got %b exp 0", imem_bus.imem_req); end
    rst_n = 1;
    settle();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_sequential();
    test_ack_delay();
    test_jump_branch();
    test_stall();
    test_exc_wait();
    test_misaligned();
    test_exc_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
